// File: rtl/arbitro_pkg.sv
// Shared constants and state type for the 16-way round-robin arbiter.
package arbitro_pkg;

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned SEL_W   = 4;

  typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping past 15.
module rr_pick16
  import arbitro_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr16_32bits.sv
// Round-robin arbiter: grants one of 16 requesters for up to MAX_BEATS words and pushes
// the accepted words through a registered valid/ready output stage.
module arbitro_rr16_32bits
  import arbitro_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]         sel,
  output logic                     busy,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready
);

  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BEATS - 1);

  arb_state_t       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CntW-1:0]  beat_cnt_q;

  logic             found;
  logic [SEL_W-1:0] winner;
  logic             slot_free;
  logic             accept;
  logic             release_grant;
  logic [WIDTH-1:0] sel_word;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (found),
    .idx   (winner)
  );

  assign busy          = (state_q == BUSY);
  assign slot_free     = !out_valid || out_ready;
  assign accept        = busy && req[sel] && slot_free;
  assign release_grant = busy && (!req[sel] || (accept && (beat_cnt_q == LastBeat)));

  always_comb begin
    ack      = '0;
    ack[sel] = accept;
  end

  always_comb begin
    sel_word = '0;
    case (sel)
      4'd0:  sel_word = data_in[0*WIDTH +: WIDTH];
      4'd1:  sel_word = data_in[1*WIDTH +: WIDTH];
      4'd2:  sel_word = data_in[2*WIDTH +: WIDTH];
      4'd3:  sel_word = data_in[3*WIDTH +: WIDTH];
      4'd4:  sel_word = data_in[4*WIDTH +: WIDTH];
      4'd5:  sel_word = data_in[5*WIDTH +: WIDTH];
      4'd6:  sel_word = data_in[6*WIDTH +: WIDTH];
      4'd7:  sel_word = data_in[7*WIDTH +: WIDTH];
      4'd8:  sel_word = data_in[8*WIDTH +: WIDTH];
      4'd9:  sel_word = data_in[9*WIDTH +: WIDTH];
      4'd10: sel_word = data_in[10*WIDTH +: WIDTH];
      4'd11: sel_word = data_in[11*WIDTH +: WIDTH];
      4'd12: sel_word = data_in[12*WIDTH +: WIDTH];
      4'd13: sel_word = data_in[13*WIDTH +: WIDTH];
      4'd14: sel_word = data_in[14*WIDTH +: WIDTH];
      4'd15: sel_word = data_in[15*WIDTH +: WIDTH];
      default: sel_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      sel        <= '0;
      gnt        <= '0;
      beat_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q    <= BUSY;
            sel        <= winner;
            gnt        <= NUM_REQ'(1) << winner;
            beat_cnt_q <= '0;
          end
        end
        BUSY: begin
          if (accept) beat_cnt_q <= beat_cnt_q + CntW'(1);
          // Pointer moves past the released owner so it queues behind everyone else.
          if (release_grant) begin
            state_q <= IDLE;
            gnt     <= '0;
            ptr_q   <= sel + SEL_W'(1);
          end
        end
      endcase
    end
  end

  // Output register drains regardless of arbiter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_word;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
